// File: rtl/vga_timing_pkg.sv
// Shared timing constants, widths and FSM states for the VGA sync receiver.
// Defaults describe the 800x600 @ 60 Hz mode (40 MHz pixel clock).
package vga_timing_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam int H_TOTAL  = 1056;
  localparam int H_ACTIVE = 800;
  localparam int H_RISE_X = 841;
  localparam int H_FALL_X = 969;
  localparam int V_TOTAL  = 628;
  localparam int V_ACTIVE = 600;
  localparam int V_RISE_Y = 601;
  localparam int V_RISE_X = 2;

  localparam logic [7:0] ERR_MAX = 8'hff;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// One-register edge detector for a sync input already in the clk domain.
// rise/fall are valid in the same cycle the input changes.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/vga_sync_rx.sv
// Recovers x/y/de from h_sync/v_sync and tracks timing lock.
// Counters free-run and are snapped onto the source at sync rises.
module vga_sync_rx #(
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_RISE_X = vga_timing_pkg::H_RISE_X,
  parameter int H_FALL_X = vga_timing_pkg::H_FALL_X,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_RISE_Y = vga_timing_pkg::V_RISE_Y,
  parameter int V_RISE_X = vga_timing_pkg::V_RISE_X
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         h_sync,
  input  logic                         v_sync,
  output logic [vga_timing_pkg::XW-1:0] x,
  output logic [vga_timing_pkg::YW-1:0] y,
  output logic                         de,
  output logic                         locked,
  output logic                         sync_err,
  output logic [7:0]                   err_cnt
);

  import vga_timing_pkg::*;

  localparam logic [XW-1:0] X1  = XW'(1);
  localparam logic [XW-1:0] HT  = XW'(H_TOTAL);
  localparam logic [XW-1:0] HA  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HR  = XW'(H_RISE_X);
  localparam logic [XW-1:0] HF  = XW'(H_FALL_X);
  localparam logic [XW-1:0] HR1 = XW'(H_RISE_X + 1);
  localparam logic [XW-1:0] VX  = XW'(V_RISE_X);
  localparam logic [XW-1:0] VX1 = XW'(V_RISE_X + 1);
  localparam logic [YW-1:0] Y1  = YW'(1);
  localparam logic [YW-1:0] VT  = YW'(V_TOTAL);
  localparam logic [YW-1:0] VA  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VR  = YW'(V_RISE_Y);

  logic          h_rise;
  logic          h_fall;
  logic          v_rise;
  logic          unused_v_fall;
  logic [XW-1:0] x_nx;
  logic [YW-1:0] y_nx;
  logic          h_err;
  logic          v_err;
  logic          err;
  logic          de_nx;
  state_t        state;
  state_t        state_nx;

  sync_edge_det u_h_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (h_sync),
    .rise (h_rise),
    .fall (h_fall)
  );

  sync_edge_det u_v_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (v_sync),
    .rise (v_rise),
    .fall (unused_v_fall)
  );

  // A missing or misplaced edge both show up as a mismatch here.
  assign h_err = (h_rise ^ (x == HR)) | (h_fall ^ (x == HF));
  assign v_err = v_rise ^ ((y == VR) & (x == VX));

  always_comb begin
    x_nx = (x == HT) ? X1 : x + X1;
    y_nx = y;
    if (x == HT) y_nx = (y == VT) ? Y1 : y + Y1;
    if (v_rise) begin
      x_nx = VX1;
      y_nx = VR;
    end else if (h_rise) begin
      x_nx = HR1;
    end
  end

  always_comb begin
    state_nx = state;
    err      = 1'b0;
    unique case (state)
      SEARCH: begin
        if (v_rise) state_nx = ALIGN;
      end
      ALIGN: begin
        if (h_err || v_err) begin
          state_nx = SEARCH;
          err      = 1'b1;
        end else if (v_rise) begin
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (h_err || v_err) begin
          state_nx = SEARCH;
          err      = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  assign de_nx = (state_nx == LOCKED)
               & (x_nx >= X1) & (x_nx <= HA)
               & (y_nx >= Y1) & (y_nx <= VA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x        <= X1;
      y        <= Y1;
      state    <= SEARCH;
      locked   <= 1'b0;
      de       <= 1'b0;
      sync_err <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      x        <= x_nx;
      y        <= y_nx;
      state    <= state_nx;
      locked   <= (state_nx == LOCKED);
      de       <= de_nx;
      sync_err <= err;
      if (err && (err_cnt != ERR_MAX))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a reduced 40x20 raster.
// A bench-side source counter drives the syncs and is the reference.
module tb_vga_sync_rx;

  localparam int HT = 40;
  localparam int HA = 30;
  localparam int HR = 32;
  localparam int HF = 36;
  localparam int VT = 20;
  localparam int VA = 15;
  localparam int VR = 16;
  localparam int VX = 2;

  logic        clk;
  logic        rst;
  logic        h_sync;
  logic        v_sync;
  logic [10:0] x;
  logic [9:0]  y;
  logic        de;
  logic        locked;
  logic        sync_err;
  logic [7:0]  err_cnt;

  int checks;
  int errors;
  int sx;
  int sy;
  int de_cnt;
  bit drop_v;
  bit chk;
  bit exp_lock;

  vga_sync_rx #(
    .H_TOTAL  (HT),
    .H_ACTIVE (HA),
    .H_RISE_X (HR),
    .H_FALL_X (HF),
    .V_TOTAL  (VT),
    .V_ACTIVE (VA),
    .V_RISE_Y (VR),
    .V_RISE_X (VX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .x        (x),
    .y        (y),
    .de       (de),
    .locked   (locked),
    .sync_err (sync_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    h_sync = (sx >= HR) && (sx < HF);
    v_sync = !drop_v &&
             ((sy == VR && sx >= VX) ||
              (sy > VR && sy < VR + 4) ||
              (sy == VR + 4 && sx < VX));
  endtask

  task automatic src_step();
    @(posedge clk);
    #1;
    if (sx == HT) begin
      sx = 1;
      sy = (sy == VT) ? 1 : sy + 1;
    end else begin
      sx = sx + 1;
    end
    drive();
    if (chk) begin
      check("x", x, sx);
      check("y", y, sy);
      check("sync_err_quiet", sync_err, 0);
      check("locked", locked, exp_lock);
      check("de", de, exp_lock && sx <= HA && sy <= VA);
    end
    if (de) de_cnt++;
  endtask

  task automatic goto(input int px, input int py);
    int n;
    n = 0;
    while (!(sx == px && sy == py) && n < 3000) begin
      src_step();
      n++;
    end
    check("goto_reached", (sx == px && sy == py), 1);
  endtask

  task automatic tick(input logic h, input logic v);
    h_sync = h;
    v_sync = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    de_cnt   = 0;
    drop_v   = 0;
    chk      = 0;
    exp_lock = 0;
    rst      = 1'b0;
    sx       = 10;
    sy       = 5;
    drive();

    // reset state
    @(posedge clk);
    #2;
    check("rst_x", x, 1);
    check("rst_y", y, 1);
    check("rst_de", de, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // nominal lock: SEARCH -> ALIGN -> LOCKED
    goto(VX, VR);
    check("pre_1st_vrise", locked, 0);
    src_step();
    chk = 1;
    goto(VX, VR);
    check("pre_2nd_vrise", locked, 0);
    exp_lock = 1;
    src_step();
    check("lock_after_2nd", locked, 1);
    check("lock_x", x, VX + 1);
    check("lock_y", y, VR);

    // one full locked frame
    de_cnt = 0;
    repeat (HT * VT) src_step();
    check("de_per_frame", de_cnt, HA * VA);
    check("err_cnt_nominal", err_cnt, 0);

    // h_sync glitch inside active video
    goto(20, 5);
    chk      = 0;
    exp_lock = 0;
    h_sync   = 1'b1;
    src_step();
    check("glitch_sync_err", sync_err, 1);
    check("glitch_err_cnt", err_cnt, 1);
    check("glitch_locked", locked, 0);
    check("glitch_x_load", x, HR + 1);
    src_step();
    check("glitch_pulse_end", sync_err, 0);
    goto(VX, VR);
    src_step();
    chk = 1;
    goto(VX, VR);
    exp_lock = 1;
    src_step();
    check("relock", locked, 1);
    check("relock_err_cnt", err_cnt, 1);

    // missing v_sync pulse
    goto(1, 1);
    drop_v = 1;
    goto(VX, VR);
    chk      = 0;
    exp_lock = 0;
    src_step();
    check("miss_sync_err", sync_err, 1);
    check("miss_err_cnt", err_cnt, 2);
    check("miss_locked", locked, 0);
    check("miss_x", x, VX + 1);
    check("miss_y", y, VR);
    src_step();
    check("miss_pulse_end", sync_err, 0);
    goto(25, 8);
    drop_v = 0;
    drive();
    check("pre_rst_err_cnt", err_cnt, 2);

    // async reset mid-line, no clock edge
    #2;
    rst = 1'b0;
    #1;
    check("arst_x", x, 1);
    check("arst_y", y, 1);
    check("arst_locked", locked, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_de", de, 0);
    @(negedge clk);
    rst = 1'b1;

    // relock after mid-frame reset needs two v rises
    goto(VX, VR);
    src_step();
    check("arst_one_vrise", locked, 0);
    chk = 1;
    goto(VX, VR);
    exp_lock = 1;
    src_step();
    check("arst_relock", locked, 1);
    chk      = 0;
    exp_lock = 0;

    // saturation: each v-rise/h-glitch triple costs one error
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("sat_still_locked", locked, 1);
    repeat (100) begin
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
    check("sat_100", err_cnt, 100);
    repeat (200) begin
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
    check("sat_300", err_cnt, 255);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    check("sat_pulse", sync_err, 1);
    tick(1'b0, 1'b0);
    check("sat_pulse_end", sync_err, 0);
    check("sat_hold", err_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
